// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard/forwarding controller.
// The pipeline datapath (master) supplies stage register fields and consumes
// stall, flush and forwarding controls. The controller is the slave.
interface hazard_ctrl_if;
    logic [4:0]  i_rs1_addr_D;
    logic [4:0]  i_rs2_addr_D;
    logic [4:0]  i_rs1_addr_E;
    logic [4:0]  i_rs2_addr_E;
    logic [4:0]  i_rd_addr_E;
    logic        i_rd_wren_E;
    logic [1:0]  i_wb_sel_E;
    logic        i_pc_sel_E;
    logic [4:0]  i_rd_addr_M;
    logic        i_rd_wren_M;
    logic [1:0]  i_wb_sel_M;
    logic [4:0]  i_rd_addr_W;
    logic        i_rd_wren_W;
    logic        o_stall_F;
    logic        o_stall_D;
    logic        o_flush_D;
    logic        o_flush_E;
    logic [1:0]  o_fwd_a_E;
    logic [1:0]  o_fwd_b_E;
    logic [31:0] o_stall_cnt;
    logic [31:0] o_flush_cnt;

    modport master (
        output i_rs1_addr_D, i_rs2_addr_D, i_rs1_addr_E, i_rs2_addr_E,
        output i_rd_addr_E, i_rd_wren_E, i_wb_sel_E, i_pc_sel_E,
        output i_rd_addr_M, i_rd_wren_M, i_wb_sel_M,
        output i_rd_addr_W, i_rd_wren_W,
        input  o_stall_F, o_stall_D, o_flush_D, o_flush_E,
        input  o_fwd_a_E, o_fwd_b_E, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_rs1_addr_D, i_rs2_addr_D, i_rs1_addr_E, i_rs2_addr_E,
        input  i_rd_addr_E, i_rd_wren_E, i_wb_sel_E, i_pc_sel_E,
        input  i_rd_addr_M, i_rd_wren_M, i_wb_sel_M,
        input  i_rd_addr_W, i_rd_wren_W,
        output o_stall_F, o_stall_D, o_flush_D, o_flush_E,
        output o_fwd_a_E, o_fwd_b_E, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline (F/D/E/M/W).
// Generates F/D and D/E stall/flush controls, E-stage forwarding selects,
// holds load-use stalls for LD_LAT bubbles (legal range 1..7), and keeps
// saturating stall/flush event counters for debug.
module hazard_ctrl #(
    parameter int unsigned LD_LAT  = 1,
    parameter logic [1:0]  WB_LOAD = 2'b00,
    parameter logic [1:0]  WB_PC4  = 2'b10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    hazard_ctrl_if.slave bus
);

    typedef enum logic {
        IDLE,
        LD_STALL
    } state_t;

    // Bubbles still owed once the first stall cycle has been spent in IDLE.
    localparam logic [2:0] LAT_M1 = 3'(LD_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  bub_q, bub_d;
    logic        hz;
    logic        stall_f, stall_d, flush_d, flush_e;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // M wins over W; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] rd_m,
        input logic       wren_m,
        input logic [1:0] wb_m,
        input logic [4:0] rd_w,
        input logic       wren_w
    );
        if (wren_m && rd_m != 5'd0 && rd_m == src)
            return (wb_m == WB_PC4) ? 2'b11 : 2'b10;
        if (wren_w && rd_w != 5'd0 && rd_w == src)
            return 2'b01;
        return 2'b00;
    endfunction

    // Operand-forwarding selects for the instruction currently in E.
    always_comb begin
        fwd_a = fwd_sel(bus.i_rs1_addr_E, bus.i_rd_addr_M, bus.i_rd_wren_M,
                        bus.i_wb_sel_M, bus.i_rd_addr_W, bus.i_rd_wren_W);
        fwd_b = fwd_sel(bus.i_rs2_addr_E, bus.i_rd_addr_M, bus.i_rd_wren_M,
                        bus.i_wb_sel_M, bus.i_rd_addr_W, bus.i_rd_wren_W);
    end

    // Load in E whose destination is read by the instruction in D.
    assign hz = bus.i_rd_wren_E && (bus.i_wb_sel_E == WB_LOAD) &&
                (bus.i_rd_addr_E != 5'd0) &&
                ((bus.i_rd_addr_E == bus.i_rs1_addr_D) ||
                 (bus.i_rd_addr_E == bus.i_rs2_addr_D));

    // Next-state and stall/flush decode; a redirect always overrides a stall.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        bub_d   = bub_q;
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_pc_sel_E) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (hz) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    if (LD_LAT > 1) begin
                        state_d = LD_STALL;
                        bub_d   = LAT_M1;
                    end
                end
            end
            LD_STALL: begin
                if (bus.i_pc_sel_E) begin
                    // E should hold a bubble here; flush anyway and recover.
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    state_d = IDLE;
                    bub_d   = 3'd0;
                end else begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    if (bub_q == 3'd1) begin
                        state_d = IDLE;
                        bub_d   = 3'd0;
                    end else begin
                        bub_d = bub_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bub_d   = 3'd0;
            end
        endcase
    end

    // FSM state and bubble counter; reset aborts any stall in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            bub_q   <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    // Saturating debug counters for stall cycles and redirect events.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_d && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.i_pc_sel_E && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    // Controls are forced low for as long as reset is held.
    assign bus.o_stall_F   = i_rst_n & stall_f;
    assign bus.o_stall_D   = i_rst_n & stall_d;
    assign bus.o_flush_D   = i_rst_n & flush_d;
    assign bus.o_flush_E   = i_rst_n & flush_e;
    assign bus.o_fwd_a_E   = i_rst_n ? fwd_a : 2'b00;
    assign bus.o_fwd_b_E   = i_rst_n ? fwd_b : 2'b00;
    assign bus.o_stall_cnt = stall_cnt_q;
    assign bus.o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: one instance with LD_LAT=1, one with
// LD_LAT=3, driven with identical stimulus. Directed scenarios first, then
// randomized traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1_D;
        logic [4:0] rs2_D;
        logic [4:0] rs1_E;
        logic [4:0] rs2_E;
        logic [4:0] rd_E;
        logic       wren_E;
        logic [1:0] wb_E;
        logic       pc_sel;
        logic [4:0] rd_M;
        logic       wren_M;
        logic [1:0] wb_M;
        logic [4:0] rd_W;
        logic       wren_W;
    } in_t;

    localparam logic [1:0] WB_LOAD = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    logic i_clk;
    logic i_rst_n;
    in_t  cur;
    int   checks;
    int   errors;

    hazard_ctrl_if if1 ();
    hazard_ctrl_if if3 ();

    hazard_ctrl #(.LD_LAT(1), .WB_LOAD(WB_LOAD), .WB_PC4(WB_PC4)) dut1 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (if1.slave)
    );

    hazard_ctrl #(.LD_LAT(3), .WB_LOAD(WB_LOAD), .WB_PC4(WB_PC4)) dut3 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (if3.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic apply(input in_t v);
        if1.i_rs1_addr_D = v.rs1_D;  if3.i_rs1_addr_D = v.rs1_D;
        if1.i_rs2_addr_D = v.rs2_D;  if3.i_rs2_addr_D = v.rs2_D;
        if1.i_rs1_addr_E = v.rs1_E;  if3.i_rs1_addr_E = v.rs1_E;
        if1.i_rs2_addr_E = v.rs2_E;  if3.i_rs2_addr_E = v.rs2_E;
        if1.i_rd_addr_E  = v.rd_E;   if3.i_rd_addr_E  = v.rd_E;
        if1.i_rd_wren_E  = v.wren_E; if3.i_rd_wren_E  = v.wren_E;
        if1.i_wb_sel_E   = v.wb_E;   if3.i_wb_sel_E   = v.wb_E;
        if1.i_pc_sel_E   = v.pc_sel; if3.i_pc_sel_E   = v.pc_sel;
        if1.i_rd_addr_M  = v.rd_M;   if3.i_rd_addr_M  = v.rd_M;
        if1.i_rd_wren_M  = v.wren_M; if3.i_rd_wren_M  = v.wren_M;
        if1.i_wb_sel_M   = v.wb_M;   if3.i_wb_sel_M   = v.wb_M;
        if1.i_rd_addr_W  = v.rd_W;   if3.i_rd_addr_W  = v.rd_W;
        if1.i_rd_wren_W  = v.wren_W; if3.i_rd_wren_W  = v.wren_W;
    endtask

    // Reference: which stage, if any, supplies register x to E.
    function automatic logic [1:0] ref_fwd(input logic [4:0] x, input in_t v);
        if (x == 5'd0) return 2'b00;
        if (v.wren_M && v.rd_M == x) return (v.wb_M == WB_PC4) ? 2'b11 : 2'b10;
        if (v.wren_W && v.rd_W == x) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_hz(input in_t v);
        return v.wren_E && v.wb_E == WB_LOAD && v.rd_E != 5'd0 &&
               (v.rd_E == v.rs1_D || v.rd_E == v.rs2_D);
    endfunction

    // Reference outputs {stall_F, stall_D, flush_D, flush_E, fwd_a, fwd_b}
    // given the number of bubbles still owed from an earlier load-use.
    function automatic logic [7:0] ref_out(input in_t v, input int owed);
        logic stall;
        logic [1:0] fl;
        stall = 1'b0;
        fl    = 2'b00;
        if (v.pc_sel) fl = 2'b11;
        else if (owed > 0 || ref_hz(v)) begin
            stall = 1'b1;
            fl    = 2'b01;
        end
        return {stall, stall, fl, ref_fwd(v.rs1_E, v), ref_fwd(v.rs2_E, v)};
    endfunction

    function automatic int ref_owed(input in_t v, input int owed, input int lat);
        if (v.pc_sel) return 0;
        if (owed > 0) return owed - 1;
        if (ref_hz(v)) return lat - 1;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        cur = '0;
        apply(cur);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        cur = '0;
        cur.rd_E = 5'd3; cur.wren_E = 1'b1; cur.wb_E = WB_LOAD; cur.rs1_D = 5'd3;
        cur.rd_M = 5'd7; cur.wren_M = 1'b1; cur.wb_M = WB_ALU;
        cur.rs1_E = 5'd7; cur.rs2_E = 5'd7; cur.pc_sel = 1'b1;
        apply(cur);
        #1;
        got = {if1.o_stall_F, if1.o_stall_D, if1.o_flush_D, if1.o_flush_E,
               if1.o_fwd_a_E, if1.o_fwd_b_E};
        checks++;
        if (got !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000", got);
        end
        checks++;
        if (if3.o_stall_cnt !== 32'd0 || if3.o_flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0",
                     if3.o_stall_cnt, if3.o_flush_cnt);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_fwd_priority();
        do_reset();
        @(negedge i_clk);
        cur = '0;
        cur.rd_M = 5'd5; cur.wren_M = 1'b1; cur.wb_M = WB_ALU;
        cur.rd_W = 5'd5; cur.wren_W = 1'b1; cur.rs1_E = 5'd5;
        apply(cur);
        #1;
        checks++;
        if (if1.o_fwd_a_E !== 2'b10) begin
            errors++;
            $display("FAIL fwd_m_over_w: got %b expected 10", if1.o_fwd_a_E);
        end
        cur.wren_M = 1'b0;
        apply(cur);
        #1;
        checks++;
        if (if1.o_fwd_a_E !== 2'b01) begin
            errors++;
            $display("FAIL fwd_from_w: got %b expected 01", if1.o_fwd_a_E);
        end
    endtask

    task automatic test_pc4_fwd();
        @(negedge i_clk);
        cur = '0;
        cur.rd_M = 5'd1; cur.wren_M = 1'b1; cur.wb_M = WB_PC4;
        cur.rs2_E = 5'd1; cur.rs1_E = 5'd2;
        apply(cur);
        #1;
        checks++;
        if (if1.o_fwd_b_E !== 2'b11 || if1.o_fwd_a_E !== 2'b00) begin
            errors++;
            $display("FAIL fwd_pc4: got a=%b b=%b expected a=00 b=11",
                     if1.o_fwd_a_E, if1.o_fwd_b_E);
        end
    endtask

    task automatic test_x0();
        @(negedge i_clk);
        cur = '0;
        cur.rd_M = 5'd0; cur.wren_M = 1'b1; cur.wb_M = WB_ALU; cur.rs1_E = 5'd0;
        cur.rd_E = 5'd0; cur.wren_E = 1'b1; cur.wb_E = WB_LOAD; cur.rs1_D = 5'd0;
        apply(cur);
        #1;
        checks++;
        if (if1.o_fwd_a_E !== 2'b00 || if1.o_stall_D !== 1'b0 || if3.o_stall_D !== 1'b0) begin
            errors++;
            $display("FAIL x0_suppress: got fwd_a=%b stall1=%b stall3=%b expected 00/0/0",
                     if1.o_fwd_a_E, if1.o_stall_D, if3.o_stall_D);
        end
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        @(negedge i_clk);
        cur = '0;
        cur.rd_E = 5'd3; cur.wren_E = 1'b1; cur.wb_E = WB_LOAD; cur.rs2_D = 5'd3;
        apply(cur);
        #1;
        checks++;
        if ({if1.o_stall_F, if1.o_stall_D, if1.o_flush_E} !== 3'b111) begin
            errors++;
            $display("FAIL lu1_stall: got F=%b D=%b flushE=%b expected 1/1/1",
                     if1.o_stall_F, if1.o_stall_D, if1.o_flush_E);
        end
        // Load moves to M, bubble in E, consumer still in D.
        @(negedge i_clk);
        cur = '0;
        cur.rd_M = 5'd3; cur.wren_M = 1'b1; cur.wb_M = WB_LOAD; cur.rs2_D = 5'd3;
        apply(cur);
        #1;
        checks++;
        if ({if1.o_stall_F, if1.o_stall_D, if1.o_flush_E} !== 3'b000) begin
            errors++;
            $display("FAIL lu1_release: got F=%b D=%b flushE=%b expected 0/0/0",
                     if1.o_stall_F, if1.o_stall_D, if1.o_flush_E);
        end
        // Consumer in E, load in W.
        @(negedge i_clk);
        cur = '0;
        cur.rs2_E = 5'd3; cur.rd_W = 5'd3; cur.wren_W = 1'b1;
        apply(cur);
        #1;
        checks++;
        if (if1.o_fwd_b_E !== 2'b01 || if1.o_stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL lu1_consume: got fwd_b=%b stall_cnt=%0d expected 01/1",
                     if1.o_fwd_b_E, if1.o_stall_cnt);
        end
    endtask

    task automatic test_load_use_lat3();
        logic [3:0] seen;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            cur = '0;
            if (c == 0) begin
                cur.rd_E = 5'd3; cur.wren_E = 1'b1; cur.wb_E = WB_LOAD; cur.rs2_D = 5'd3;
            end
            apply(cur);
            #1;
            seen[c] = if3.o_stall_D & if3.o_stall_F & if3.o_flush_E;
        end
        checks++;
        if (seen !== 4'b0111) begin
            errors++;
            $display("FAIL lu3_length: got stall pattern %b expected 0111", seen);
        end
        checks++;
        if (if3.o_stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL lu3_count: got %0d expected 3", if3.o_stall_cnt);
        end
        // Abort a stall with reset during its second cycle.
        do_reset();
        @(negedge i_clk);
        cur = '0;
        cur.rd_E = 5'd3; cur.wren_E = 1'b1; cur.wb_E = WB_LOAD; cur.rs2_D = 5'd3;
        apply(cur);
        @(negedge i_clk);
        cur = '0;
        apply(cur);
        #1;
        checks++;
        if (if3.o_stall_D !== 1'b1) begin
            errors++;
            $display("FAIL lu3_cycle2: got stall_D=%b expected 1", if3.o_stall_D);
        end
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({if3.o_stall_F, if3.o_stall_D, if3.o_flush_E} !== 3'b000 ||
            if3.o_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL lu3_reset_abort: got F=%b D=%b flushE=%b cnt=%0d expected 0/0/0/0",
                     if3.o_stall_F, if3.o_stall_D, if3.o_flush_E, if3.o_stall_cnt);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checks++;
        if (if3.o_stall_D !== 1'b0) begin
            errors++;
            $display("FAIL lu3_after_reset: got stall_D=%b expected 0", if3.o_stall_D);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        @(negedge i_clk);
        cur = '0;
        cur.rd_E = 5'd4; cur.wren_E = 1'b1; cur.wb_E = WB_LOAD; cur.rs1_D = 5'd4;
        cur.pc_sel = 1'b1;
        apply(cur);
        #1;
        checks++;
        if ({if1.o_flush_D, if1.o_flush_E, if1.o_stall_F, if1.o_stall_D} !== 4'b1100) begin
            errors++;
            $display("FAIL redirect_beats_hz: got fD=%b fE=%b sF=%b sD=%b expected 1/1/0/0",
                     if1.o_flush_D, if1.o_flush_E, if1.o_stall_F, if1.o_stall_D);
        end
        @(negedge i_clk);
        cur = '0;
        apply(cur);
        #1;
        checks++;
        if (if1.o_flush_cnt !== 32'd1 || if1.o_flush_D !== 1'b0) begin
            errors++;
            $display("FAIL redirect_count: got cnt=%0d fD=%b expected 1/0",
                     if1.o_flush_cnt, if1.o_flush_D);
        end
        // Redirect arriving while the LD_LAT=3 instance is mid-stall.
        @(negedge i_clk);
        cur = '0;
        cur.rd_E = 5'd4; cur.wren_E = 1'b1; cur.wb_E = WB_LOAD; cur.rs1_D = 5'd4;
        apply(cur);
        @(negedge i_clk);
        cur = '0;
        cur.pc_sel = 1'b1;
        apply(cur);
        #1;
        checks++;
        if ({if3.o_flush_D, if3.o_flush_E, if3.o_stall_F} !== 3'b110) begin
            errors++;
            $display("FAIL redirect_in_stall: got fD=%b fE=%b sF=%b expected 1/1/0",
                     if3.o_flush_D, if3.o_flush_E, if3.o_stall_F);
        end
        @(negedge i_clk);
        cur = '0;
        apply(cur);
        #1;
        checks++;
        if (if3.o_stall_D !== 1'b0) begin
            errors++;
            $display("FAIL redirect_to_idle: got stall_D=%b expected 0", if3.o_stall_D);
        end
    endtask

    task automatic test_flush_saturation();
        logic [32:0] want;
        do_reset();
        @(negedge i_clk);
        cur = '0;
        apply(cur);
        force dut1.flush_cnt_q = 32'hFFFF_FFFD;
        #1 release dut1.flush_cnt_q;
        #1;
        checks++;
        if (if1.o_flush_cnt !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL sat_preload: got %h expected fffffffd", if1.o_flush_cnt);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge i_clk);
            cur.pc_sel = 1'b1;
            apply(cur);
            @(negedge i_clk);
            cur.pc_sel = 1'b0;
            apply(cur);
            #1;
            want = 33'h0_FFFF_FFFD + 33'(k);
            if (want > 33'h0_FFFF_FFFF) want = 33'h0_FFFF_FFFF;
            checks++;
            if (if1.o_flush_cnt !== want[31:0]) begin
                errors++;
                $display("FAIL sat_flush_cnt[%0d]: got %h expected %h", k,
                         if1.o_flush_cnt, want[31:0]);
            end
        end
    endtask

    task automatic test_random();
        int owed1, owed3;
        int scnt1, scnt3, fcnt;
        logic [7:0] exp1, exp3, got1, got3;
        do_reset();
        owed1 = 0; owed3 = 0; scnt1 = 0; scnt3 = 0; fcnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            cur.rs1_D  = 5'($urandom_range(0, 3));
            cur.rs2_D  = 5'($urandom_range(0, 3));
            cur.rs1_E  = 5'($urandom_range(0, 3));
            cur.rs2_E  = 5'($urandom_range(0, 3));
            cur.rd_E   = 5'($urandom_range(0, 3));
            cur.wren_E = 1'($urandom);
            cur.wb_E   = 2'($urandom);
            cur.pc_sel = ($urandom_range(0, 7) == 0);
            cur.rd_M   = 5'($urandom_range(0, 3));
            cur.wren_M = 1'($urandom);
            cur.wb_M   = 2'($urandom);
            cur.rd_W   = 5'($urandom_range(0, 3));
            cur.wren_W = 1'($urandom);
            apply(cur);
            #1;
            exp1 = ref_out(cur, owed1);
            exp3 = ref_out(cur, owed3);
            got1 = {if1.o_stall_F, if1.o_stall_D, if1.o_flush_D, if1.o_flush_E,
                    if1.o_fwd_a_E, if1.o_fwd_b_E};
            got3 = {if3.o_stall_F, if3.o_stall_D, if3.o_flush_D, if3.o_flush_E,
                    if3.o_fwd_a_E, if3.o_fwd_b_E};
            checks++;
            if (got1 !== exp1) begin
                errors++;
                $display("FAIL rand_lat1[%0d]: got %b expected %b", i, got1, exp1);
            end
            checks++;
            if (got3 !== exp3) begin
                errors++;
                $display("FAIL rand_lat3[%0d]: got %b expected %b", i, got3, exp3);
            end
            checks++;
            if (if1.o_stall_cnt !== 32'(scnt1) || if3.o_stall_cnt !== 32'(scnt3) ||
                if1.o_flush_cnt !== 32'(fcnt) || if3.o_flush_cnt !== 32'(fcnt)) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got s1=%0d s3=%0d f1=%0d f3=%0d expected %0d %0d %0d %0d",
                         i, if1.o_stall_cnt, if3.o_stall_cnt, if1.o_flush_cnt,
                         if3.o_flush_cnt, scnt1, scnt3, fcnt, fcnt);
            end
            if (exp1[6]) scnt1++;
            if (exp3[6]) scnt3++;
            if (cur.pc_sel) fcnt++;
            owed1 = ref_owed(cur, owed1, 1);
            owed3 = ref_owed(cur, owed3, 3);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_rst_n = 1'b0;
        cur     = '0;
        apply(cur);
        test_reset();
        test_fwd_priority();
        test_pc4_fwd();
        test_x0();
        test_load_use_lat1();
        test_load_use_lat3();
        test_redirect();
        test_flush_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage RV32I pipeline (F/D/E/M/W).
- Drives the stall and flush inputs of the F/D and D/E pipeline registers.
- Drives the E-stage operand-forwarding mux selects.
- Holds load-use stalls for a configurable number of bubbles via a small FSM.
- Keeps saturating stall/flush event counters for debug.

Parameters:
LD_LAT, 1, bubbles inserted per load-use hazard (legal range 1..7)
WB_LOAD, 2'b00, wb_sel encoding that denotes a load
WB_PC4, 2'b10, wb_sel encoding that denotes PC+4 writeback (JAL/JALR)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_rs1_addr_D  in  5  rs1 field of instruction in D
i_rs2_addr_D  in  5  rs2 field of instruction in D
i_rs1_addr_E  in  5  rs1 field of instruction in E
i_rs2_addr_E  in  5  rs2 field of instruction in E
i_rd_addr_E  in  5  destination register in E
i_rd_wren_E  in  1  register write enable in E
i_wb_sel_E  in  2  writeback select in E
i_pc_sel_E  in  1  taken branch/jump resolved in E
i_rd_addr_M  in  5  destination register in M
i_rd_wren_M  in  1  register write enable in M
i_wb_sel_M  in  2  writeback select in M
i_rd_addr_W  in  5  destination register in W
i_rd_wren_W  in  1  register write enable in W
o_stall_F  out  1  hold PC
o_stall_D  out  1  hold F/D register
o_flush_D  out  1  clear F/D register to NOP
o_flush_E  out  1  clear D/E register to NOP
o_fwd_a_E  out  2  operand-A source: 00 regfile, 01 W wb_data, 10 M alu_data, 11 M PC+4
o_fwd_b_E  out  2  operand-B (rs2) source, same encoding
o_stall_cnt  out  32  count of cycles with o_stall_D=1
o_flush_cnt  out  32  count of redirect events

Behaviour:
- Reset:
  - FSM = IDLE, bubble counter = 0, o_stall_cnt = o_flush_cnt = 0.
  - While i_rst_n=0, all stall, flush and fwd outputs are forced to 0.
  - Reset asserted mid-stall aborts the stall immediately.
- Forwarding (combinational, evaluated per operand X in {rs1_E, rs2_E}):
  - If rd_wren_M, rd_M!=0 and rd_M==X: select 11 when wb_sel_M==WB_PC4, otherwise 10.
  - Else if rd_wren_W, rd_W!=0 and rd_W==X: select 01.
  - Otherwise select 00.
  - M always has priority over W. A load is never forwarded from M; the load-use stall guarantees this.
- Load-use detect:
  - hz = rd_wren_E & (wb_sel_E==WB_LOAD) & rd_E!=0 & (rd_E==rs1_D | rd_E==rs2_D).
- FSM states:
  - IDLE:
    - If hz and !pc_sel_E: assert o_stall_F, o_stall_D and o_flush_E this cycle.
    - If LD_LAT>1, move to LD_STALL with cnt = LD_LAT-1; otherwise stay in IDLE.
  - LD_STALL:
    - Assert o_stall_F, o_stall_D and o_flush_E.
    - Decrement cnt each cycle; return to IDLE when cnt reaches 1.
- Stall timing: total stall length is exactly LD_LAT cycles. The consumer then enters E with the load in W and selects forwarding code 01.
- Redirect:
  - pc_sel_E=1 asserts o_flush_D and o_flush_E for exactly 1 cycle and forces o_stall_F = o_stall_D = 0.
  - Redirect beats a load-use stall in the same cycle.
  - A redirect seen in LD_STALL (illegal, because E holds a bubble) still flushes and returns the FSM to IDLE.
- Counters:
  - o_stall_cnt increments on each cycle with o_stall_D=1.
  - o_flush_cnt increments on each cycle with pc_sel_E=1.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- Register x0 never triggers forwarding or stalls.

Test Plan:
- Forwarding priority: add x5 in M, sub x5 in W, E reads rs1=x5 → o_fwd_a_E=10. Remove the M write → 01.
- PC+4 forwarding: jal x1 in M (wb_sel_M=WB_PC4), E reads rs2=x1 → o_fwd_b_E=11.
- x0 suppression: rd_M=0 with rd_wren_M=1, E rs1=0 → fwd=00, no stall.
- Load-use, LD_LAT=1: lw x3 in E, D reads rs2=x3 → stall_F/stall_D/flush_E high 1 cycle. Next cycle outputs low, consumer in E shows fwd_b=01. o_stall_cnt=1.
- Load-use, LD_LAT=3: same stimulus → stall held exactly 3 cycles, then IDLE. Assert i_rst_n=0 during cycle 2 → outputs 0 immediately and counters cleared.
- Redirect vs load-use: pc_sel_E=1 together with hz=1 → flush_D=flush_E=1, stall_F=0, o_flush_cnt increments by 1. Preloading the counter to near-saturation and holding pc_sel_E → o_flush_cnt sticks at FFFF_FFFF.
